// File: rtl/clk_interval_timer.sv
`default_nettype none
// ============================================================================
//  Module   : clk_interval_timer
//  Purpose  : Multi-channel start/stop interval timer. Each channel counts
//             clock cycles between a start event and a stop event, captures
//             the interval and holds it for a valid/ack handshake.
//  Config   : TIMER_SATURATE_EN defined   -> counter sticks at all-ones on
//                                            overflow (capture = all-ones)
//             TIMER_SATURATE_EN undefined -> counter wraps modulo 2^CNT_W
//  Ports    : clk        system clock, rising edge
//             reset      asynchronous active-high reset
//             clear      synchronous clear of all channels
//             start      [N_CH]        per-channel start event (level)
//             stop       [N_CH]        per-channel stop event (level)
//             cap_ack    [N_CH]        per-channel capture acknowledge
//             running    [N_CH]        channel in RUN state
//             count      [N_CH*CNT_W]  live counters, ch i at [i*CNT_W +: CNT_W]
//             cap_value  [N_CH*CNT_W]  captured intervals, same packing
//             cap_valid  [N_CH]        capture held, not yet acknowledged
//             cap_lost   [N_CH]        sticky: capture overwritten before ack
//             ovf        [N_CH]        sticky: counter passed all-ones
//  Revision : 1.0  initial release
// ============================================================================
module clk_interval_timer #(
  parameter int N_CH      = 4,
  parameter int CNT_W     = 32,
  parameter int RETRIGGER = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [N_CH-1:0]       start,
  input  logic [N_CH-1:0]       stop,
  input  logic [N_CH-1:0]       cap_ack,
  output logic [N_CH-1:0]       running,
  output logic [N_CH*CNT_W-1:0] count,
  output logic [N_CH*CNT_W-1:0] cap_value,
  output logic [N_CH-1:0]       cap_valid,
  output logic [N_CH-1:0]       cap_lost,
  output logic [N_CH-1:0]       ovf
);

  localparam logic [0:0]       ST_IDLE = 1'b0;
  localparam logic [0:0]       ST_RUN  = 1'b1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [0:0]       state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic [CNT_W-1:0] cap_q, cap_d;
      logic             valid_q, valid_d;
      logic             lost_q, lost_d;
      logic             ovf_q, ovf_d;
      logic             capture;

      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        valid_d = valid_q;
        lost_d  = lost_q;
        ovf_d   = ovf_q;
        capture = 1'b0;

        if (clear) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          cap_d   = '0;
          valid_d = 1'b0;
          lost_d  = 1'b0;
          ovf_d   = 1'b0;
        end else begin
          case (state_q)
            ST_IDLE: begin
              // stop dominates a simultaneous start, so a zero-length
              // interval never launches
              if (start[gi] && !stop[gi]) begin
                state_d = ST_RUN;
                cnt_d   = CNT_ONE;
                ovf_d   = 1'b0;
              end
            end
            ST_RUN: begin
              if (stop[gi]) begin
                // capture the pre-edge count; count itself freezes
                state_d = ST_IDLE;
                capture = 1'b1;
                cap_d   = cnt_q;
              end else if (start[gi] && (RETRIGGER != 0)) begin
                cnt_d = CNT_ONE;
                ovf_d = 1'b0;
              end else if (cnt_q == CNT_MAX) begin
                ovf_d = 1'b1;
`ifdef TIMER_SATURATE_EN
                cnt_d = CNT_MAX;
`else
                cnt_d = '0;
`endif
              end else begin
                cnt_d = cnt_q + CNT_ONE;
              end
            end
            default: state_d = ST_IDLE;
          endcase

          // a fresh capture wins over an ack in the same cycle; it is only
          // counted as lost when the previous one was never acknowledged
          if (capture) begin
            valid_d = 1'b1;
            if (valid_q && !cap_ack[gi]) begin
              lost_d = 1'b1;
            end
          end else if (valid_q && cap_ack[gi]) begin
            valid_d = 1'b0;
          end
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          cap_q   <= '0;
          valid_q <= 1'b0;
          lost_q  <= 1'b0;
          ovf_q   <= 1'b0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          cap_q   <= cap_d;
          valid_q <= valid_d;
          lost_q  <= lost_d;
          ovf_q   <= ovf_d;
        end
      end

      assign running[gi]                     = (state_q == ST_RUN);
      assign count[gi*CNT_W +: CNT_W]        = cnt_q;
      assign cap_value[gi*CNT_W +: CNT_W]    = cap_q;
      assign cap_valid[gi]                   = valid_q;
      assign cap_lost[gi]                    = lost_q;
      assign ovf[gi]                         = ovf_q;
    end
  endgenerate

endmodule
`default_nettype wire
